// File: rtl/demux_sched.sv
// Scheduler and output buffer for a 1:2 demultiplexer. It routes valid/ready input words to
// channel Y or X by an alternate, burst or forced policy, with a one-entry buffer per channel.
module demux_sched #(
  parameter int unsigned WIDTH     = 10,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] x_data,
  output logic             x_valid,
  input  logic             x_ready,
  output logic [WIDTH-1:0] y_data,
  output logic             y_valid,
  input  logic             y_ready,
  output logic             sel,
  output logic [CNT_W-1:0] cnt_x,
  output logic [CNT_W-1:0] cnt_y
);

  localparam int unsigned BC_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic {SEL_Y = 1'b0, SEL_X = 1'b1} sel_e;
  typedef enum logic [1:0] {
    M_ALT    = 2'b00,
    M_BURST  = 2'b01,
    M_FORCEY = 2'b10,
    M_FORCEX = 2'b11
  } mode_e;

  sel_e             sel_q, sel_d;
  mode_e            mode_q, mode_d, mode_eff;
  logic [BC_W-1:0]  burst_q, burst_d;
  logic [WIDTH-1:0] x_data_q, x_data_d, y_data_q, y_data_d;
  logic             x_valid_q, x_valid_d, y_valid_q, y_valid_d;
  logic [CNT_W-1:0] cnt_x_q, cnt_x_d, cnt_y_q, cnt_y_d;
  logic             accept, acc_x, acc_y, at_boundary;

  // Ready depends only on the current target buffer, never on in_valid.
  assign in_ready = (sel_q == SEL_X) ? (!x_valid_q || x_ready) : (!y_valid_q || y_ready);
  assign accept   = in_valid && in_ready;
  assign acc_x    = accept && (sel_q == SEL_X);
  assign acc_y    = accept && (sel_q == SEL_Y);

  assign at_boundary = (burst_q == BC_W'(0));
  assign mode_eff    = at_boundary ? mode_e'(mode) : mode_q;

  // State registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      sel_q     <= SEL_Y;
      mode_q    <= M_ALT;
      burst_q   <= '0;
      x_data_q  <= '0;
      x_valid_q <= 1'b0;
      y_data_q  <= '0;
      y_valid_q <= 1'b0;
      cnt_x_q   <= '0;
      cnt_y_q   <= '0;
    end else begin
      sel_q     <= sel_d;
      mode_q    <= mode_d;
      burst_q   <= burst_d;
      x_data_q  <= x_data_d;
      x_valid_q <= x_valid_d;
      y_data_q  <= y_data_d;
      y_valid_q <= y_valid_d;
      cnt_x_q   <= cnt_x_d;
      cnt_y_q   <= cnt_y_d;
    end
  end

  // Policy next state: mode is only re-latched on a burst boundary
  always_comb begin
    sel_d   = sel_q;
    burst_d = burst_q;
    mode_d  = mode_q;
    if (at_boundary) begin
      mode_d = mode_e'(mode);
      if (mode[1]) sel_d = sel_e'(mode[0]);
    end
    if (accept) begin
      unique case (mode_eff)
        M_ALT: begin
          sel_d   = (sel_q == SEL_X) ? SEL_Y : SEL_X;
          burst_d = '0;
        end
        M_BURST: begin
          if (burst_q == BC_W'(BURST_LEN - 1)) begin
            burst_d = '0;
            sel_d   = (sel_q == SEL_X) ? SEL_Y : SEL_X;
          end else begin
            burst_d = burst_q + BC_W'(1);
          end
        end
        M_FORCEY: begin
          sel_d   = SEL_Y;
          burst_d = '0;
        end
        M_FORCEX: begin
          sel_d   = SEL_X;
          burst_d = '0;
        end
        default: begin
          sel_d   = sel_q;
          burst_d = '0;
        end
      endcase
    end
  end

  // Channel buffers: a load wins over a drain so a full buffer can stream at 1 word/clk
  always_comb begin
    x_data_d  = x_data_q;
    x_valid_d = x_valid_q;
    y_data_d  = y_data_q;
    y_valid_d = y_valid_q;
    cnt_x_d   = cnt_x_q;
    cnt_y_d   = cnt_y_q;
    if (acc_x) begin
      x_data_d  = in_data;
      x_valid_d = 1'b1;
      cnt_x_d   = cnt_x_q + CNT_W'(1);
    end else if (x_valid_q && x_ready) begin
      x_data_d  = '0;
      x_valid_d = 1'b0;
    end
    if (acc_y) begin
      y_data_d  = in_data;
      y_valid_d = 1'b1;
      cnt_y_d   = cnt_y_q + CNT_W'(1);
    end else if (y_valid_q && y_ready) begin
      y_data_d  = '0;
      y_valid_d = 1'b0;
    end
  end

  assign x_data  = x_data_q;
  assign x_valid = x_valid_q;
  assign y_data  = y_data_q;
  assign y_valid = y_valid_q;
  assign sel     = sel_q;
  assign cnt_x   = cnt_x_q;
  assign cnt_y   = cnt_y_q;

endmodule

// File: tb/tb_demux_sched.sv
// Directed bench for demux_sched: a per-channel scoreboard is filled on accept and drained
// by a negedge monitor as each channel handshakes.
module tb_demux_sched;

  localparam int unsigned WIDTH = 10;
  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       mode;
  logic [WIDTH-1:0] x_data, y_data;
  logic             x_valid, y_valid, x_ready, y_ready;
  logic             sel;
  logic [CNT_W-1:0] cnt_x, cnt_y;

  int vectors = 0;
  int errs    = 0;
  logic [WIDTH-1:0] qx[$];
  logic [WIDTH-1:0] qy[$];

  demux_sched #(.WIDTH(WIDTH), .BURST_LEN(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready),
    .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready), .sel(sel),
    .cnt_x(cnt_x), .cnt_y(cnt_y)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endfunction

  // Scoreboard monitor: a handshake seen at negedge completes on the next rising edge
  always @(negedge clk) begin
    if (rst) begin
      if (x_valid && x_ready) begin
        if (qx.size() == 0) chk("x_unexpected", 32'(x_data), 32'hFFFF_FFFF);
        else chk("x_data", 32'(x_data), 32'(qx.pop_front()));
      end
      if (y_valid && y_ready) begin
        if (qy.size() == 0) chk("y_unexpected", 32'(y_data), 32'hFFFF_FFFF);
        else chk("y_data", 32'(y_data), 32'(qy.pop_front()));
      end
      if (!x_valid) chk("x_idle_zero", 32'(x_data), 32'h0);
      if (!y_valid) chk("y_idle_zero", 32'(y_data), 32'h0);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one word, expecting it to route to channel ch (0=Y, 1=X)
  task automatic send(input logic [WIDTH-1:0] d, input logic ch);
    int n;
    n = 0;
    in_data  = d;
    in_valid = 1'b1;
    #0;
    chk("sel_before_accept", 32'(sel), 32'(ch));
    while (!in_ready && n < 50) begin
      step(1);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'h1);
    step(1);
    in_valid = 1'b0;
    in_data  = '0;
    if (ch) begin
      qx.push_back(d);
      chk("x_latency_valid", 32'(x_valid), 32'h1);
      chk("x_latency_data", 32'(x_data), 32'(d));
    end else begin
      qy.push_back(d);
      chk("y_latency_valid", 32'(y_valid), 32'h1);
      chk("y_latency_data", 32'(y_data), 32'(d));
    end
  endtask

  initial begin
    rst = 1'b0; in_data = '0; in_valid = 1'b0; mode = 2'b00; x_ready = 1'b1; y_ready = 1'b1;
    step(2);
    rst = 1'b1;
    #1;
    chk("rst_sel", 32'(sel), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_cnt_x", 32'(cnt_x), 32'h0);
    chk("rst_cnt_y", 32'(cnt_y), 32'h0);
    chk("rst_x_valid", 32'(x_valid), 32'h0);
    chk("rst_y_valid", 32'(y_valid), 32'h0);

    // Alternate: odd words to Y, even words to X
    for (int i = 1; i <= 6; i++) send(WIDTH'(i), (i % 2) == 0);
    step(2);
    chk("t1_cnt_y", 32'(cnt_y), 32'd3);
    chk("t1_cnt_x", 32'(cnt_x), 32'd3);

    // Burst of 4: 1..4 to Y, 5..8 to X, back to Y afterwards
    mode = 2'b01;
    for (int i = 1; i <= 8; i++) send(WIDTH'(i), i > 4);
    step(2);
    chk("t2_sel_after", 32'(sel), 32'h0);
    chk("t2_cnt_y", 32'(cnt_y), 32'd7);
    chk("t2_cnt_x", 32'(cnt_x), 32'd7);

    // Backpressure on Y stalls input in strict order
    mode = 2'b00;
    y_ready = 1'b0;
    send(10'h155, 1'b0);
    send(10'h2AA, 1'b1);
    in_data = 10'h3FF;
    in_valid = 1'b1;
    #0;
    chk("t3_stall_ready", 32'(in_ready), 32'h0);
    step(2);
    chk("t3_stall_ready2", 32'(in_ready), 32'h0);
    chk("t3_y_hold", 32'(y_data), 32'h155);
    chk("t3_x_drained", 32'(x_valid), 32'h0);
    y_ready = 1'b1;
    #1;
    chk("t3_ready_release", 32'(in_ready), 32'h1);
    step(1);
    in_valid = 1'b0;
    qy.push_back(10'h3FF);
    chk("t3_y_reload", 32'(y_data), 32'h3FF);
    chk("t3_y_valid", 32'(y_valid), 32'h1);
    step(2);
    chk("t3_q_empty", 32'(qx.size() + qy.size()), 32'h0);

    // Mid-burst switch to force X waits for the burst boundary
    mode = 2'b10;
    step(1);
    chk("t4_forced_y", 32'(sel), 32'h0);
    mode = 2'b01;
    send(10'h011, 1'b0);
    send(10'h022, 1'b0);
    mode = 2'b11;
    send(10'h033, 1'b0);
    send(10'h044, 1'b0);
    for (int i = 0; i < 4; i++) send(WIDTH'(10'h100 + i), 1'b1);
    step(3);
    chk("t4_y_idle", 32'(y_valid), 32'h0);
    chk("t4_sel_x", 32'(sel), 32'h1);

    // Fill both buffers then reset for one clock
    x_ready = 1'b0;
    y_ready = 1'b0;
    mode = 2'b00;
    send(10'h0AB, 1'b1);
    send(10'h0CD, 1'b0);
    chk("t5_full_ready", 32'(in_ready), 32'h0);
    rst = 1'b0;
    step(1);
    qx.delete();
    qy.delete();
    rst = 1'b1;
    x_ready = 1'b1;
    y_ready = 1'b1;
    #1;
    chk("t5_x_valid", 32'(x_valid), 32'h0);
    chk("t5_y_valid", 32'(y_valid), 32'h0);
    chk("t5_x_data", 32'(x_data), 32'h0);
    chk("t5_y_data", 32'(y_data), 32'h0);
    chk("t5_cnt_x", 32'(cnt_x), 32'h0);
    chk("t5_cnt_y", 32'(cnt_y), 32'h0);
    chk("t5_sel", 32'(sel), 32'h0);
    chk("t5_in_ready", 32'(in_ready), 32'h1);

    // Force Y for 300 words: counter wraps to 44
    mode = 2'b10;
    for (int i = 0; i < 300; i++) send(WIDTH'(i), 1'b0);
    step(3);
    chk("t6_cnt_y", 32'(cnt_y), 32'd44);
    chk("t6_cnt_x", 32'(cnt_x), 32'd0);
    chk("t6_q_empty", 32'(qx.size() + qy.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
